// File: rtl/wiener_pkg.sv
// -----------------------------------------------------------------------------
// wiener_pkg
// Shared definitions for the block statistics streamer: default pixel width and
// block size, the matching log2 constant, and the controller state type.
// No ports (package).
// -----------------------------------------------------------------------------
package wiener_pkg;

  localparam int DATA_WIDTH_DEF    = 8;
  localparam int TOTAL_SAMPLES_DEF = 64;
  localparam int LOG2_SAMPLES_DEF  = $clog2(TOTAL_SAMPLES_DEF);

  // ACCUM   : collect one block of pixels and running sums
  // COMPUTE : single cycle to register mean and variance
  // REPLAY  : stream the stored block back out in arrival order
  // GAP     : single idle cycle that clears the accumulators
  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    COMPUTE = 2'd1,
    REPLAY  = 2'd2,
    GAP     = 2'd3
  } state_e;

endpackage

// File: rtl/block_stats_streamer_if.sv
// -----------------------------------------------------------------------------
// block_stats_streamer_if
// Bundles the pixel input handshake, frame configuration and the statistics /
// replay output stream of block_stats_streamer.
//   master : traffic source and result consumer (drives data_in, data_valid,
//            blocks_per_frame; observes everything else)
//   slave  : the streamer itself
// -----------------------------------------------------------------------------
interface block_stats_streamer_if
  import wiener_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [DATA_WIDTH-1:0]   data_in;
  logic                    data_valid;
  logic                    in_ready;
  logic [31:0]             blocks_per_frame;
  logic [2*DATA_WIDTH-1:0] mean_of_block;
  logic [2*DATA_WIDTH-1:0] variance_of_block;
  logic                    stats_ready;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    data_out_valid;
  logic [31:0]             block_count;
  logic                    frame_done;

  modport master (
    output data_in, data_valid, blocks_per_frame,
    input  in_ready, mean_of_block, variance_of_block, stats_ready,
           data_out, data_out_valid, block_count, frame_done
  );

  modport slave (
    input  data_in, data_valid, blocks_per_frame,
    output in_ready, mean_of_block, variance_of_block, stats_ready,
           data_out, data_out_valid, block_count, frame_done
  );

endinterface

// File: rtl/block_buffer.sv
// -----------------------------------------------------------------------------
// block_buffer
// TOTAL_SAMPLES x DATA_WIDTH pixel store for one block.
//   clk     : write clock
//   wr_en   : write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr : write slot
//   wr_data : pixel to store
//   rd_addr : read slot
//   rd_data : combinational read of rd_addr
// -----------------------------------------------------------------------------
module block_buffer
  import wiener_pkg::*;
#(
  parameter  int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter  int TOTAL_SAMPLES = TOTAL_SAMPLES_DEF,
  localparam int ADDR_W        = $clog2(TOTAL_SAMPLES)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [TOTAL_SAMPLES];

  // NOTE: the storage array has no reset; every slot is written before it is
  // read back, and a reset term would turn the array into plain flops.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/block_stats_streamer.sv
// -----------------------------------------------------------------------------
// block_stats_streamer
// Collects TOTAL_SAMPLES pixels, computes the floored block mean and variance,
// then replays the block unchanged alongside the statistics.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of block_stats_streamer_if
//           in  : data_in, data_valid, blocks_per_frame
//           out : in_ready, mean_of_block, variance_of_block, stats_ready,
//                 data_out, data_out_valid, block_count, frame_done
// Timing: last input transfer on edge t -> COMPUTE -> stats_ready and pixel 0
// visible two cycles after the transfer cycle.
// -----------------------------------------------------------------------------
module block_stats_streamer
  import wiener_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int TOTAL_SAMPLES = TOTAL_SAMPLES_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  block_stats_streamer_if.slave bus
);

  localparam int LOG2_N = $clog2(TOTAL_SAMPLES);
  localparam int SUM_W  = DATA_WIDTH + LOG2_N;
  localparam int SQ_W   = 2*DATA_WIDTH + LOG2_N;
  localparam int OUT_W  = 2*DATA_WIDTH;

  localparam logic [LOG2_N-1:0] LAST_SLOT = LOG2_N'(TOTAL_SAMPLES - 1);
  localparam logic [LOG2_N:0]   RD_END    = (LOG2_N+1)'(TOTAL_SAMPLES);
  localparam logic [LOG2_N:0]   RD_LAST   = (LOG2_N+1)'(TOTAL_SAMPLES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q,          state_d;
  logic [LOG2_N-1:0]       in_count_q,       in_count_d;
  logic [SUM_W-1:0]        sum_q,            sum_d;
  logic [SQ_W-1:0]         sum_sq_q,         sum_sq_d;
  logic [LOG2_N:0]         rd_idx_q,         rd_idx_d;
  logic [31:0]             bpf_q,            bpf_d;
  logic [31:0]             block_count_q,    block_count_d;
  logic                    in_ready_q,       in_ready_d;
  logic                    stats_ready_q,    stats_ready_d;
  logic [DATA_WIDTH-1:0]   data_out_q,       data_out_d;
  logic                    data_out_valid_q, data_out_valid_d;
  logic                    frame_done_q,     frame_done_d;
  logic [OUT_W-1:0]        mean_q,           mean_d;
  logic [OUT_W-1:0]        variance_q,       variance_d;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic                  transfer;
  logic [OUT_W-1:0]      px_sq;
  logic [DATA_WIDTH-1:0] mean_w;
  logic [OUT_W-1:0]      mean_sq;
  logic [OUT_W-1:0]      ex2;
  logic [31:0]           block_inc;
  logic                  block_wrap;
  logic [31:0]           bpf_in;
  logic [LOG2_N-1:0]     rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  // in_ready_q is only high in ACCUM, so it doubles as the state qualifier.
  assign transfer = bus.data_valid && in_ready_q;

  assign px_sq = {{DATA_WIDTH{1'b0}}, bus.data_in} * {{DATA_WIDTH{1'b0}}, bus.data_in};

  // Dividing by a power-of-two block size is a plain bit select; both
  // quotients floor, and floor(E[x^2]) >= floor(E[x])^2 keeps the difference
  // non-negative.
  assign mean_w  = sum_q[SUM_W-1:LOG2_N];
  assign ex2     = sum_sq_q[SQ_W-1:LOG2_N];
  assign mean_sq = {{DATA_WIDTH{1'b0}}, mean_w} * {{DATA_WIDTH{1'b0}}, mean_w};

  // ">=" rather than "==" so a frame length lowered below the current index
  // still wraps instead of counting through 2^32.
  assign block_inc  = block_count_q + 32'd1;
  assign block_wrap = (block_inc >= bpf_q);

  assign bpf_in = (bus.blocks_per_frame == 32'd0) ? 32'd1 : bus.blocks_per_frame;

  // COMPUTE fetches slot 0; REPLAY fetches the slot that becomes visible next.
  assign rd_addr = (state_q == REPLAY) ? rd_idx_q[LOG2_N-1:0] : '0;

  block_buffer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .TOTAL_SAMPLES (TOTAL_SAMPLES)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (transfer),
    .wr_addr (in_count_q),
    .wr_data (bus.data_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d          = state_q;
    in_count_d       = in_count_q;
    sum_d            = sum_q;
    sum_sq_d         = sum_sq_q;
    rd_idx_d         = rd_idx_q;
    bpf_d            = bpf_q;
    block_count_d    = block_count_q;
    in_ready_d       = in_ready_q;
    stats_ready_d    = 1'b0;
    data_out_d       = data_out_q;
    data_out_valid_d = data_out_valid_q;
    frame_done_d     = 1'b0;
    mean_d           = mean_q;
    variance_d       = variance_q;

    case (state_q)
      ACCUM: begin
        if (transfer) begin
          sum_d      = sum_q + {{LOG2_N{1'b0}}, bus.data_in};
          sum_sq_d   = sum_sq_q + {{LOG2_N{1'b0}}, px_sq};
          in_count_d = in_count_q + LOG2_N'(1);
          if (in_count_q == '0) begin
            bpf_d = bpf_in;
          end
          if (in_count_q == LAST_SLOT) begin
            state_d    = COMPUTE;
            in_ready_d = 1'b0;
          end
        end
      end

      COMPUTE: begin
        mean_d           = {{DATA_WIDTH{1'b0}}, mean_w};
        variance_d       = ex2 - mean_sq;
        stats_ready_d    = 1'b1;
        data_out_d       = rd_data;
        data_out_valid_d = 1'b1;
        rd_idx_d         = (LOG2_N+1)'(1);
        state_d          = REPLAY;
      end

      REPLAY: begin
        if (rd_idx_q != RD_END) begin
          data_out_d   = rd_data;
          rd_idx_d     = rd_idx_q + (LOG2_N+1)'(1);
          // Registered, so raised while loading the last slot to coincide
          // with that pixel on the output.
          frame_done_d = (rd_idx_q == RD_LAST) && block_wrap;
        end else begin
          data_out_d       = '0;
          data_out_valid_d = 1'b0;
          rd_idx_d         = '0;
          block_count_d    = block_wrap ? 32'd0 : block_inc;
          state_d          = GAP;
        end
      end

      GAP: begin
        sum_d      = '0;
        sum_sq_d   = '0;
        in_count_d = '0;
        in_ready_d = 1'b1;
        state_d    = ACCUM;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ACCUM;
      in_count_q       <= '0;
      sum_q            <= '0;
      sum_sq_q         <= '0;
      rd_idx_q         <= '0;
      bpf_q            <= 32'd1;
      block_count_q    <= '0;
      in_ready_q       <= 1'b1;
      stats_ready_q    <= 1'b0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      frame_done_q     <= 1'b0;
      mean_q           <= '0;
      variance_q       <= '0;
    end else begin
      state_q          <= state_d;
      in_count_q       <= in_count_d;
      sum_q            <= sum_d;
      sum_sq_q         <= sum_sq_d;
      rd_idx_q         <= rd_idx_d;
      bpf_q            <= bpf_d;
      block_count_q    <= block_count_d;
      in_ready_q       <= in_ready_d;
      stats_ready_q    <= stats_ready_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      frame_done_q     <= frame_done_d;
      mean_q           <= mean_d;
      variance_q       <= variance_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready          = in_ready_q;
  assign bus.mean_of_block     = mean_q;
  assign bus.variance_of_block = variance_q;
  assign bus.stats_ready       = stats_ready_q;
  assign bus.data_out          = data_out_q;
  assign bus.data_out_valid    = data_out_valid_q;
  assign bus.block_count       = block_count_q;
  assign bus.frame_done        = frame_done_q;

endmodule

// File: tb/tb_block_stats_streamer.sv
// -----------------------------------------------------------------------------
// tb_block_stats_streamer
// Directed bench for block_stats_streamer (8-bit pixels, 64-pixel blocks,
// two blocks per frame unless changed). Expected statistics are hand-computed
// constants; expected replay data is the stimulus table itself.
// -----------------------------------------------------------------------------
module tb_block_stats_streamer;

  localparam int DW = 8;
  localparam int N  = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  block_stats_streamer_if #(.DATA_WIDTH(DW)) bus ();

  block_stats_streamer #(
    .DATA_WIDTH    (DW),
    .TOTAL_SAMPLES (N)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_px [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle past it; outputs are read here, inputs driven
  // here take effect at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: constant val, 1: alternating 0/255, 2: ramp 0..N-1
  task automatic fill(input int mode, input logic [DW-1:0] val);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       exp_px[i] = val;
        1:       exp_px[i] = (i % 2 == 0) ? 8'd0 : 8'd255;
        default: exp_px[i] = 8'(i);
      endcase
    end
  endtask

  // Sends exp_px honouring in_ready; optional valid gap every 3rd cycle.
  // Afterwards data_valid is left high with junk (hold) or low.
  task automatic send_block(input string tag, input bit stall, input bit hold);
    int i   = 0;
    int cyc = 0;
    bit xfer;
    while (i < N && cyc < 4*N) begin
      if (stall && (cyc % 3 == 2)) begin
        bus.data_valid = 1'b0;
        bus.data_in    = 8'hEE;
      end else begin
        bus.data_valid = 1'b1;
        bus.data_in    = exp_px[i];
      end
      xfer = bus.data_valid && bus.in_ready;
      tick();
      if (xfer) i++;
      cyc++;
    end
    check({tag, " accepted"}, 64'(i), 64'(N));
    bus.data_valid = hold;
    bus.data_in    = hold ? 8'd200 : 8'd0;
  endtask

  // Called right after the last transfer edge; stats must appear one edge later.
  task automatic wait_stats(input string tag);
    int edges = 1;
    while (bus.stats_ready !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    check({tag, " latency"}, 64'(edges), 64'd2);
  endtask

  task automatic expect_block(input string tag, input logic [15:0] exp_mean,
                              input logic [15:0] exp_var, input logic [31:0] exp_bc,
                              input bit exp_fd);
    int px_err  = 0;
    int bc_err  = 0;
    int ctl_err = 0;
    int fd_cnt  = 0;
    int fd_pos  = N;
    wait_stats(tag);
    check({tag, " mean"}, 64'(bus.mean_of_block), 64'(exp_mean));
    check({tag, " variance"}, 64'(bus.variance_of_block), 64'(exp_var));
    for (int k = 0; k < N; k++) begin
      if (bus.data_out_valid !== 1'b1 || bus.data_out !== exp_px[k]) px_err++;
      if (bus.block_count !== exp_bc) bc_err++;
      if (bus.stats_ready !== (k == 0) || bus.in_ready !== 1'b0) ctl_err++;
      if (bus.frame_done === 1'b1) begin
        fd_cnt++;
        fd_pos = k;
      end
      tick();
    end
    check({tag, " replay pixel errors"}, 64'(px_err), 64'd0);
    check({tag, " block_count errors"}, 64'(bc_err), 64'd0);
    check({tag, " replay control errors"}, 64'(ctl_err), 64'd0);
    check({tag, " frame_done count"}, 64'(fd_cnt), 64'(exp_fd));
    check({tag, " frame_done position"}, 64'(fd_pos), exp_fd ? 64'(N-1) : 64'(N));
    // Now in GAP.
    check({tag, " gap data_out"}, {bus.data_out_valid, bus.data_out}, 64'd0);
    check({tag, " gap in_ready"}, 64'(bus.in_ready), 64'd0);
    check({tag, " mean held"}, 64'(bus.mean_of_block), 64'(exp_mean));
  endtask

  initial begin
    bus.data_in          = '0;
    bus.data_valid       = 1'b0;
    bus.blocks_per_frame = 32'd2;
    rst_n                = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset outputs", {bus.stats_ready, bus.data_out_valid, bus.frame_done,
                            bus.data_out, bus.block_count}, 64'd0);
    check("reset stats", {bus.mean_of_block, bus.variance_of_block}, 64'd0);

    // Constant 100s: mean 100, variance 0.
    fill(0, 8'd100);
    send_block("A", 1'b0, 1'b0);
    expect_block("A", 16'd100, 16'd0, 32'd0, 1'b0);

    // Alternating 0/255: mean 127, variance 32512 - 16129 = 16383; ends frame.
    fill(1, 8'd0);
    send_block("B", 1'b0, 1'b0);
    expect_block("B", 16'd127, 16'd16383, 32'd1, 1'b1);

    // Ramp with valid gaps: mean 31, variance 1333 - 961 = 372; block_count wrapped.
    fill(2, 8'd0);
    send_block("C", 1'b1, 1'b0);
    expect_block("C", 16'd31, 16'd372, 32'd0, 1'b0);

    // data_valid held high with junk through COMPUTE/REPLAY/GAP.
    fill(0, 8'd20);
    send_block("D", 1'b0, 1'b1);
    expect_block("D", 16'd20, 16'd0, 32'd1, 1'b1);
    tick();  // GAP -> ACCUM edge still sees the junk pixel
    fill(0, 8'd9);
    send_block("E", 1'b0, 1'b0);
    expect_block("E", 16'd9, 16'd0, 32'd0, 1'b0);

    // Reset while replay pixel 10 is on the output.
    fill(2, 8'd0);
    send_block("F", 1'b0, 1'b0);
    wait_stats("F");
    repeat (10) tick();
    check("F slot 10", 64'(bus.data_out), 64'd10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("replay reset in_ready", 64'(bus.in_ready), 64'd1);
    check("replay reset outputs", {bus.stats_ready, bus.data_out_valid, bus.frame_done,
                                   bus.data_out, bus.block_count}, 64'd0);
    check("replay reset stats", {bus.mean_of_block, bus.variance_of_block}, 64'd0);

    // Reset partway through accumulating ten 255s; they must not leak.
    bus.data_valid = 1'b1;
    bus.data_in    = 8'd255;
    repeat (10) tick();
    bus.data_valid = 1'b0;
    rst_n          = 1'b0;
    tick();
    rst_n = 1'b1;
    check("accum reset in_ready", 64'(bus.in_ready), 64'd1);

    // Fresh block of 7s with blocks_per_frame = 0 (treated as 1): every block ends a frame.
    bus.blocks_per_frame = 32'd0;
    fill(0, 8'd7);
    send_block("G", 1'b0, 1'b0);
    expect_block("G", 16'd7, 16'd0, 32'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
